// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_pkg                                                      |
// | Purpose: Shared constants for the 160x120 RGB332 framebuffer fill    |
// |          path: geometry, address shift, colour field positions,      |
// |          and the grant / fill state encodings.                       |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;
  localparam int ADR_SHIFT = 2;
  localparam int ADR_W     = 17;

  // RGB332 pixel layout: RRR GGG BB
  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  // Bus grant owner
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_HOST = 2'd1;
  localparam logic [1:0] GNT_FILL = 2'd2;

  // Fill sequencer
  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_SETUP = 2'd1;
  localparam logic [1:0] FS_WRITE = 2'd2;
  localparam logic [1:0] FS_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fb_fill_walker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_fill_walker                                              |
// | Purpose: Accepts a rectangle-fill command, clips it to the           |
// |          framebuffer and walks it row by row, presenting one pixel   |
// |          write at a time on a simple req/ack handshake.              |
// | Ports  : I_clk, I_rst_n           clock, async active-low reset      |
// |          I_cmd_* / O_cmd_ready    command handshake and fields       |
// |          O_req, I_ack             pixel write request / completion   |
// |          O_adr, O_dat             byte address and colour of pixel   |
// |          O_busy, O_done           fill status, completion pulse      |
// |          O_pix_count              pixels written by this fill        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fb_fill_walker #(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int ADR_SHIFT = fb_pkg::ADR_SHIFT,
  parameter int ADR_W     = fb_pkg::ADR_W
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_cmd_valid,
  output logic             O_cmd_ready,
  input  logic [7:0]       I_cmd_x,
  input  logic [6:0]       I_cmd_y,
  input  logic [8:0]       I_cmd_w,
  input  logic [7:0]       I_cmd_h,
  input  logic [7:0]       I_cmd_color,
  output logic             O_req,
  input  logic             I_ack,
  output logic [ADR_W-1:0] O_adr,
  output logic [7:0]       O_dat,
  output logic             O_busy,
  output logic             O_done,
  output logic [15:0]      O_pix_count
);
  import fb_pkg::*;

  logic [1:0]  r_state;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [8:0]  r_w;
  logic [7:0]  r_h;
  logic [7:0]  r_color;
  logic [8:0]  r_x_end;
  logic [7:0]  r_y_end;
  logic [7:0]  r_cur_x;
  logic [6:0]  r_cur_y;
  logic [15:0] r_pix;

  // Clip: sums are widened so x+w and y+h cannot wrap before the min().
  logic [9:0] w_x_sum;
  logic [8:0] w_y_sum;
  logic [8:0] w_x_end;
  logic [7:0] w_y_end;
  logic       w_empty;
  logic       w_x_last;
  logic       w_y_last;

  assign w_x_sum  = {2'b00, r_x} + {1'b0, r_w};
  assign w_y_sum  = {2'b00, r_y} + {1'b0, r_h};
  assign w_x_end  = (w_x_sum > 10'(FB_WIDTH))  ? 9'(FB_WIDTH)  : w_x_sum[8:0];
  assign w_y_end  = (w_y_sum > 9'(FB_HEIGHT))  ? 8'(FB_HEIGHT) : w_y_sum[7:0];
  assign w_empty  = (r_w == 9'd0) || (r_h == 8'd0) ||
                    ({1'b0, r_x} >= 9'(FB_WIDTH)) || ({1'b0, r_y} >= 8'(FB_HEIGHT));
  assign w_x_last = (({1'b0, r_cur_x} + 9'd1) == r_x_end);
  assign w_y_last = (({1'b0, r_cur_y} + 8'd1) == r_y_end);

  // Row base address: y*160 as (y<<7)+(y<<5) keeps multipliers out of the path.
  logic [ADR_W-1:0] w_row;
  logic [ADR_W-1:0] w_idx;

  generate
    if (FB_WIDTH == 160) begin : g_row_shift_add
      assign w_row = (ADR_W'(r_cur_y) << 7) + (ADR_W'(r_cur_y) << 5);
    end else begin : g_row_mul
      assign w_row = ADR_W'(r_cur_y) * ADR_W'(FB_WIDTH);
    end
  endgenerate

  assign w_idx = w_row + ADR_W'(r_cur_x);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= FS_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
      r_pix   <= '0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (I_cmd_valid) begin
            r_x     <= I_cmd_x;
            r_y     <= I_cmd_y;
            r_w     <= I_cmd_w;
            r_h     <= I_cmd_h;
            r_color <= I_cmd_color;
            r_state <= FS_SETUP;
          end
        end
        FS_SETUP: begin
          r_pix   <= '0;
          r_x_end <= w_x_end;
          r_y_end <= w_y_end;
          r_cur_x <= r_x;
          r_cur_y <= r_y;
          r_state <= w_empty ? FS_DONE : FS_WRITE;
        end
        FS_WRITE: begin
          if (I_ack) begin
            r_pix <= r_pix + 16'd1;
            if (w_x_last) begin
              r_cur_x <= r_x;
              if (w_y_last) begin
                r_state <= FS_DONE;
              end else begin
                r_cur_y <= r_cur_y + 7'd1;
              end
            end else begin
              r_cur_x <= r_cur_x + 8'd1;
            end
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign O_cmd_ready = (r_state == FS_IDLE);
  assign O_busy      = (r_state != FS_IDLE);
  assign O_done      = (r_state == FS_DONE);
  assign O_req       = (r_state == FS_WRITE);
  assign O_adr       = w_idx << ADR_SHIFT;
  assign O_dat       = r_color;
  assign O_pix_count = r_pix;

endmodule
`default_nettype wire

// File: rtl/fb_fill_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_fill_arbiter                                             |
// | Purpose: Shares the framebuffer Wishbone slave port between the      |
// |          SPI-bridge host and the rectangle fill engine, with a       |
// |          round-robin grant that is re-decided after every transfer.  |
// | Ports  : I_clk, I_rst_n           clock, async active-low reset      |
// |          I_cmd_* / O_cmd_ready    fill command                       |
// |          I_h_* / O_h_*            host Wishbone (slave side)         |
// |          O_m_* / I_m_*            framebuffer Wishbone (master side) |
// |          O_busy, O_done, O_pix_count  fill status                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fb_fill_arbiter #(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int ADR_SHIFT = fb_pkg::ADR_SHIFT,
  parameter int ADR_W     = fb_pkg::ADR_W
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_cmd_valid,
  output logic             O_cmd_ready,
  input  logic [7:0]       I_cmd_x,
  input  logic [6:0]       I_cmd_y,
  input  logic [8:0]       I_cmd_w,
  input  logic [7:0]       I_cmd_h,
  input  logic [7:0]       I_cmd_color,
  input  logic [ADR_W-1:0] I_h_adr,
  input  logic [7:0]       I_h_dat,
  input  logic             I_h_we,
  input  logic             I_h_stb,
  input  logic             I_h_cyc,
  output logic             O_h_ack,
  output logic [7:0]       O_h_dat,
  output logic [ADR_W-1:0] O_m_adr,
  output logic [7:0]       O_m_dat,
  output logic             O_m_we,
  output logic             O_m_stb,
  output logic             O_m_cyc,
  input  logic             I_m_ack,
  input  logic [7:0]       I_m_dat,
  output logic             O_busy,
  output logic             O_done,
  output logic [15:0]      O_pix_count
);
  import fb_pkg::*;

  logic             w_f_req;
  logic             w_f_ack;
  logic [ADR_W-1:0] w_f_adr;
  logic [7:0]       w_f_dat;
  logic             w_h_req;

  fb_fill_walker #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .ADR_SHIFT (ADR_SHIFT),
    .ADR_W     (ADR_W)
  ) u_walker (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_cmd_valid (I_cmd_valid),
    .O_cmd_ready (O_cmd_ready),
    .I_cmd_x     (I_cmd_x),
    .I_cmd_y     (I_cmd_y),
    .I_cmd_w     (I_cmd_w),
    .I_cmd_h     (I_cmd_h),
    .I_cmd_color (I_cmd_color),
    .O_req       (w_f_req),
    .I_ack       (w_f_ack),
    .O_adr       (w_f_adr),
    .O_dat       (w_f_dat),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_pix_count (O_pix_count)
  );

  assign w_h_req = I_h_stb & I_h_cyc;

  logic [1:0] r_grant;
  logic       r_last_host;
  logic [1:0] w_grant_next;

  // Ownership is only handed out from NONE; the mandatory NONE cycle after
  // each transfer is what gives the other requester its turn.
  always_comb begin
    w_grant_next = r_grant;
    case (r_grant)
      GNT_NONE: begin
        if (w_h_req && w_f_req) begin
          w_grant_next = r_last_host ? GNT_FILL : GNT_HOST;
        end else if (w_h_req) begin
          w_grant_next = GNT_HOST;
        end else if (w_f_req) begin
          w_grant_next = GNT_FILL;
        end
      end
      // A host abandoning its strobe frees the bus without an ack.
      GNT_HOST: if (I_m_ack || !w_h_req) w_grant_next = GNT_NONE;
      GNT_FILL: if (I_m_ack)             w_grant_next = GNT_NONE;
      default:                           w_grant_next = GNT_NONE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_grant     <= GNT_NONE;
      r_last_host <= 1'b0;
    end else begin
      r_grant <= w_grant_next;
      if (r_grant == GNT_NONE && w_grant_next == GNT_HOST) r_last_host <= 1'b1;
      if (r_grant == GNT_NONE && w_grant_next == GNT_FILL) r_last_host <= 1'b0;
    end
  end

  always_comb begin
    O_m_adr = '0;
    O_m_dat = '0;
    O_m_we  = 1'b0;
    O_m_stb = 1'b0;
    O_m_cyc = 1'b0;
    O_h_ack = 1'b0;
    O_h_dat = '0;
    w_f_ack = 1'b0;
    case (r_grant)
      GNT_HOST: begin
        O_m_adr = I_h_adr;
        O_m_dat = I_h_dat;
        O_m_we  = I_h_we;
        O_m_stb = I_h_stb;
        O_m_cyc = I_h_cyc;
        O_h_ack = I_m_ack;
        O_h_dat = I_m_dat;
      end
      GNT_FILL: begin
        O_m_adr = w_f_adr;
        O_m_dat = w_f_dat;
        O_m_we  = 1'b1;
        O_m_stb = w_f_req;
        O_m_cyc = w_f_req;
        w_f_ack = I_m_ack;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_fill_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fb_fill_arbiter                                          |
// | Purpose: Self-checking bench for fb_fill_arbiter with a registered-  |
// |          ack framebuffer model and a rectangle reference model.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_fb_fill_arbiter;
  localparam int ADR_W = 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_x = '0;
  logic [6:0]       cmd_y = '0;
  logic [8:0]       cmd_w = '0;
  logic [7:0]       cmd_h = '0;
  logic [7:0]       cmd_color = '0;
  logic [ADR_W-1:0] h_adr = '0;
  logic [7:0]       h_dat = '0;
  logic             h_we = 1'b0, h_stb = 1'b0, h_cyc = 1'b0;
  logic             h_ack;
  logic [7:0]       h_rdat;
  logic [ADR_W-1:0] m_adr;
  logic [7:0]       m_wdat;
  logic             m_we, m_stb, m_cyc;
  logic             m_ack;
  logic [7:0]       m_dat;
  logic             busy, done;
  logic [15:0]      pix_count;

  always #5 clk = ~clk;

  fb_fill_arbiter dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_cmd_valid(cmd_valid), .O_cmd_ready(cmd_ready),
    .I_cmd_x(cmd_x), .I_cmd_y(cmd_y), .I_cmd_w(cmd_w), .I_cmd_h(cmd_h),
    .I_cmd_color(cmd_color),
    .I_h_adr(h_adr), .I_h_dat(h_dat), .I_h_we(h_we), .I_h_stb(h_stb), .I_h_cyc(h_cyc),
    .O_h_ack(h_ack), .O_h_dat(h_rdat),
    .O_m_adr(m_adr), .O_m_dat(m_wdat), .O_m_we(m_we), .O_m_stb(m_stb), .O_m_cyc(m_cyc),
    .I_m_ack(m_ack), .I_m_dat(m_dat),
    .O_busy(busy), .O_done(done), .O_pix_count(pix_count)
  );

  // Framebuffer model: classic registered ack, unwritten pixels read a pattern.
  logic [7:0] fb_mem [int];
  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack <= 1'b0;
    end else if (m_cyc && m_stb && !m_ack) begin
      m_ack <= 1'b1;
      if (m_we) fb_mem[int'(m_adr >> 2)] = m_wdat;
      else m_dat <= fb_mem.exists(int'(m_adr >> 2)) ? fb_mem[int'(m_adr >> 2)] : pat(int'(m_adr >> 2));
    end else begin
      m_ack <= 1'b0;
    end
  end

  // Bus monitor
  typedef struct { int adr; int dat; } wr_t;
  wr_t wq[$];
  int  gaps[$];
  int  host_acks = 0, fills_since = 0, done_cnt = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (m_cyc && m_stb && m_ack) begin
        if (m_we) begin
          wq.push_back('{adr: int'(m_adr), dat: int'(m_wdat)});
          fills_since++;
        end else begin
          if (host_acks > 0) gaps.push_back(fills_since);
          host_acks++;
          fills_since = 0;
        end
      end
    end
  end

  int  n_chk = 0, n_pass = 0;
  int  wbase = 0;
  wr_t expq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: every pixel of the rectangle intersected with 160x120, row-major.
  task automatic build_model(input int x, input int y, input int w, input int h, input int c);
    int xe, ye;
    expq.delete();
    xe = (x + w < 160) ? x + w : 160;
    ye = (y + h < 120) ? y + h : 120;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        expq.push_back('{adr: (yy * 160 + xx) * 4, dat: c});
  endtask

  task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 8'(c);
  endtask

  task automatic issue(input int x, input int y, input int w, input int h, input int c);
    bit rdy = 0;
    for (int k = 0; k < 200 && !rdy; k++) begin
      @(negedge clk);
      rdy = cmd_ready;
    end
    if (!rdy) check("ready_timeout", 0, 1);
    drive_cmd(x, y, w, h, c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wbase = wq.size();
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    if (lat < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("ready_after_done", cmd_ready, 1);
    end
  endtask

  task automatic check_writes(input string tag);
    int n, errs;
    n = wq.size() - wbase;
    errs = 0;
    check({tag, "_count"}, n, expq.size());
    for (int i = 0; i < n && i < expq.size(); i++)
      if (wq[wbase+i].adr != expq[i].adr || wq[wbase+i].dat != expq[i].dat) errs++;
    check({tag, "_data"}, errs, 0);
    check({tag, "_pix"}, pix_count, expq.size());
  endtask

  typedef struct { int x, y, w, h, c, cnt, first, last, lat; } vec_t;
  vec_t vecs[5];

  initial begin
    int lat, d0, gbase, got;
    logic [7:0] rd;

    vecs[0] = '{10, 5, 3, 2, 'hE0, 6, 3240, 3888, 0};
    vecs[1] = '{158, 119, 10, 10, 'h5A, 2, 76792, 76796, 0};
    vecs[2] = '{3, 3, 0, 5, 'hFF, 0, 0, 0, 2};
    vecs[3] = '{200, 3, 5, 5, 'h11, 0, 0, 0, 2};
    vecs[4] = '{5, 127, 4, 4, 'h22, 0, 0, 0, 2};

    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix", pix_count, 0);
    check("rst_stb_cyc_we", {m_stb, m_cyc, m_we}, 0);
    check("rst_h_ack", h_ack, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven fills: plain, clipped, degenerate
    for (int i = 0; i < 5; i++) begin
      build_model(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c);
      issue(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c);
      wait_done(500, lat);
      check_writes($sformatf("vec%0d", i));
      check($sformatf("vec%0d_cnt", i), wq.size() - wbase, vecs[i].cnt);
      if (vecs[i].cnt > 0 && wq.size() - wbase >= vecs[i].cnt) begin
        check($sformatf("vec%0d_first", i), wq[wbase].adr, vecs[i].first);
        check($sformatf("vec%0d_last", i), wq[wq.size()-1].adr, vecs[i].last);
      end
      if (vecs[i].lat != 0) check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Host strobe dropped before ack: bus released, no ack
    @(posedge clk); #1;
    h_adr = 17'(100 * 4); h_we = 1'b0; h_stb = 1'b1; h_cyc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drop_granted", m_stb, 1);
    h_stb = 1'b0; h_cyc = 1'b0;
    got = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (h_ack || m_cyc) got++;
    end
    check("drop_no_ack", got, 0);

    // Full-screen clear with interleaved host reads
    build_model(0, 0, 160, 120, 0);
    gbase = gaps.size();
    issue(0, 0, 160, 120, 0);
    h_we = 1'b0; h_stb = 1'b1; h_cyc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int p;
      p = 15000 + k * 613;
      h_adr = 17'(p * 4);
      got = 0;
      for (int j = 0; j < 200 && !got; j++) begin
        @(negedge clk);
        if (h_ack) begin got = 1; rd = h_rdat; end
      end
      if (!got) check($sformatf("host_rd%0d_timeout", k), 0, 1);
      else check($sformatf("host_rd%0d", k), rd, pat(p));
      @(posedge clk); #1;
    end
    h_stb = 1'b0; h_cyc = 1'b0;
    check("alt_count", gaps.size() - gbase, 4);
    for (int k = gbase; k < gaps.size(); k++) check($sformatf("alt_gap%0d", k - gbase), gaps[k], 1);
    wait_done(70000, lat);
    check_writes("clear");
    if (wq.size() > wbase) check("clear_last", wq[wq.size()-1].adr, 76796);

    // Reset after the 4th ack of a fill
    build_model(10, 5, 3, 2, 'hE0);
    issue(10, 5, 3, 2, 'hE0);
    d0 = done_cnt;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (wq.size() - wbase >= 4) got = 1;
    end
    if (!got) check("rst4_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {m_stb, m_cyc, m_we, h_ack}, 0);
    check("mid_rst_status", {cmd_ready, busy, done}, 3'b100);
    check("mid_rst_pix", pix_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_cnt, d0);
    issue(10, 5, 3, 2, 'hE0);
    wait_done(500, lat);
    check_writes("after_rst");

    // Command held valid during a busy fill
    build_model(20, 30, 4, 3, 'h1C);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    drive_cmd(20, 30, 4, 3, 'h1C);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    wbase = wq.size();
    drive_cmd(40, 50, 2, 2, 'h03);
    @(negedge clk);
    check("held_ready_low", cmd_ready, 0);
    wait_done(500, lat);
    check_writes("held_a");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wbase = wq.size();
    build_model(40, 50, 2, 2, 'h03);
    wait_done(500, lat);
    check_writes("held_b");

    // Randomized commands against the reference model
    for (int i = 0; i < 10; i++) begin
      int rx, ry, rw, rh, rc;
      rx = $urandom_range(0, 170); ry = $urandom_range(0, 127);
      rw = $urandom_range(0, 12);  rh = $urandom_range(0, 6);
      rc = $urandom_range(0, 255);
      build_model(rx, ry, rw, rh, rc);
      issue(rx, ry, rw, rh, rc);
      wait_done(2000, lat);
      check_writes($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
